// File: rtl/pipe_stage_fifo.sv
// In-order DEPTH-entry valid/ready buffer between pipeline stages, with flush for branch redirect.
// Optional saturating stall counter enabled by defining PIPE_STAGE_FIFO_PERF_EN.
module pipe_stage_fifo #(
    parameter int WIDTH     = 16,
    parameter int DEPTH     = 2,
    parameter int CNT_WIDTH = 32
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [WIDTH-1:0]           in_data,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [WIDTH-1:0]           out_data,
    input  logic                       flush,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic [CNT_WIDTH-1:0]       stall_cycles
);
    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam logic [CW-1:0] FULL = CW'(DEPTH);
    localparam logic [PW-1:0] LAST = PW'(DEPTH - 1);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [PW-1:0]    wr_ptr;
    logic [PW-1:0]    rd_ptr;
    logic             push;
    logic             pop;

    // Pointers wrap explicitly so DEPTH need not be a power of two.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == LAST) ? '0 : p + PW'(1);
    endfunction

    function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] v);
        return (v == '1) ? v : v + CNT_WIDTH'(1);
    endfunction

    // Handshake status comes only from registered occupancy, never from out_ready.
    assign in_ready  = (count != FULL);
    assign out_valid = (count != '0);
    assign out_data  = mem[rd_ptr];
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_ff @(posedge clk) begin
        if (reset || flush) begin
            count  <= '0;
            wr_ptr <= '0;
            rd_ptr <= '0;
        end else begin
            if (push) wr_ptr <= ptr_next(wr_ptr);
            if (pop)  rd_ptr <= ptr_next(rd_ptr);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // A push accepted in a flush cycle is deliberately dropped.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
        end else if (push && !flush) begin
            mem[wr_ptr] <= in_data;
        end
    end

`ifdef PIPE_STAGE_FIFO_PERF_EN
    logic [CNT_WIDTH-1:0] stall_cnt;

    // Counts upstream-blocked cycles; flush leaves it alone.
    always_ff @(posedge clk) begin
        if (reset)
            stall_cnt <= '0;
        else if (in_valid && !in_ready)
            stall_cnt <= sat_inc(stall_cnt);
    end

    assign stall_cycles = stall_cnt;
`else
    assign stall_cycles = '0;
`endif

endmodule

// File: doc/pipe_stage_fifo.md
# pipe_stage_fifo

Parametrised inter-stage pipeline buffer that replaces the fixed, always-loading stage registers between IF/ID/EX/MEM/WB. It carries an opaque payload of `WIDTH` bits through a `DEPTH`-entry in-order queue with valid/ready handshakes on both sides, which gives real per-stage stall and back-pressure. It also supports a synchronous flush that squashes younger in-flight instructions on a taken branch. An optional saturating stall-cycle counter supports performance analysis.

## Interface
- `WIDTH`, 16, payload width in bits (packed control word plus data fields); ≥1
- `DEPTH`, 2, number of entries; 1..8; need not be a power of two
- `CNT_WIDTH`, 32, width of stall counter; ≥1
- `clk`  in  1  clock; all state updates on rising edge
- `reset`  in  1  synchronous, active-high reset
- `in_valid`  in  1  upstream stage presents a payload
- `in_ready`  out  1  buffer can accept this cycle
- `in_data`  in  WIDTH  upstream payload
- `out_valid`  out  1  head entry valid
- `out_ready`  in  1  downstream stage consumes head this cycle
- `out_data`  out  WIDTH  head payload
- `flush`  in  1  squash all held entries (branch redirect)
- `count`  out  $clog2(DEPTH+1)  occupied entries
- `stall_cycles`  out  CNT_WIDTH  upstream-blocked cycle count (see Configuration)

## Operation
- Storage: `DEPTH` x `WIDTH` array, write pointer `wr_ptr`, read pointer `rd_ptr`, occupancy `count`.
- `in_ready = (count != DEPTH)`. Driven only from registered state, with no combinational path from `out_ready`.
- `out_valid = (count != 0)`. `out_data = mem[rd_ptr]`.
- Push when `in_valid && in_ready`. Write `in_data` at `wr_ptr` and advance `wr_ptr`.
- Pop when `out_valid && out_ready`. Advance `rd_ptr`.
- Pointer advance wraps: `DEPTH-1` goes to 0.
- `count` update:
  - push only: +1
  - pop only: −1
  - push and pop together: unchanged, FIFO order preserved
  - neither: hold
- A simultaneous push and pop is legal when full. `in_ready` is 0 when full, so no push occurs; the pop still completes.
- Flush has priority over push and pop in the same cycle:
  - next cycle: `count=0`, `wr_ptr=rd_ptr=0`
  - the payload of any same-cycle push is discarded (the upstream handshake completes, and the data is intentionally killed)
  - storage contents are not cleared
- `reset` has priority over `flush`:
  - clears `count`, both pointers, all storage entries, and the stall counter
  - a reset asserted mid-stream discards all held entries

## Timing
- Reset values: `out_valid=0`, `in_ready=1`, `count=0`, `out_data=0`, `stall_cycles=0`.
- Latency: a payload pushed in cycle N appears on `out_data` with `out_valid=1` in cycle N+1 if the buffer was empty. Otherwise it appears after all older entries have been popped.
- Throughput: with `DEPTH≥2`, one transfer per cycle is sustained under continuous `in_valid`/`out_ready`. With `DEPTH=1`, the maximum rate is one transfer every 2 cycles.
- `out_data` is stable while `out_valid=1 && out_ready=0`.
- After a flush, `in_ready=1` and `out_valid=0` in the next cycle. A push in that cycle is accepted normally.

## Configuration
- `PIPE_STAGE_FIFO_PERF_EN` defined:
  - `stall_cycles` increments on every cycle with `in_valid && !in_ready`, counted before reset/flush evaluation of the same edge
  - saturates at all-ones
  - cleared by `reset` only; unaffected by `flush`
- Not defined:
  - `stall_cycles` is tied to 0
  - no counter flops are instantiated
  - the port remains present

## Test plan
- Reset: hold `reset=1` for 2 cycles with `in_valid=1` -> `out_valid=0`, `in_ready=1`, `count=0`, `out_data=0x0000`, and nothing is enqueued.
- Fill/back-pressure (`DEPTH=2`): push 0x1111, 0x2222 with `out_ready=0` -> `count=2`, `in_ready=0`, `out_data=0x1111`. Then present 0x3333 -> not accepted. Raise `out_ready` -> outputs 0x1111, 0x2222, then 0x3333 once accepted.
- Streaming (`DEPTH=2`): present 1..10 on consecutive cycles with `out_ready=1` -> `out_data` shows 1..10 on consecutive cycles starting 1 cycle after the first push, with `count` steady at 1.
- Flush with simultaneous push: `count=2`, assert `flush` and push 0xAAAA in the same cycle -> next cycle `count=0`, `out_valid=0`. A following push of 0xBBBB is the next value output, and 0xAAAA never appears.
- Wrap (`DEPTH=3`): push and pop 7 items 0x0001..0x0007 with random `out_ready` -> output order exactly 0x0001..0x0007, and `count` never exceeds 3.
- Perf counter (macro defined): hold full with `in_valid=1` for 5 cycles -> `stall_cycles=5`. With `CNT_WIDTH=4`, hold for 20 cycles -> `stall_cycles=15`, and a flush leaves it at 15. With the macro undefined -> `stall_cycles=0` throughout.
